// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits WAIT_STATES
// cycles, then presents a registered response that is held until acknowledged.
// Misaligned or out-of-range fetches return FAULT_INSTR with RspFault set.
// Optional feature: define IMEM_WRITE_EN to make the memory writable through
// the WrEn/WrAddr/WrData program-load port; otherwise it is a build-time ROM.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] FAULT_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqF,
  input  logic [31:0] AddrF,
  output logic        ReadyF,
  input  logic        Flush,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic [31:0] RspAddr,
  output logic        RspFault,
  input  logic        RspAck,
  input  logic        WrEn,
  input  logic [31:0] WrAddr,
  input  logic [31:0] WrData
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          NoWait  = (WAIT_STATES == 0);
  localparam logic [2:0]  CntLoad = NoWait ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rsp_data_q;
  logic [31:0] rsp_addr_q;
  logic        rsp_fault_q;

  logic            hs;
  logic            enter_resp;
  logic [31:0]     fetch_addr;
  logic [IdxW-1:0] fetch_idx;
  logic            fetch_fault;
  logic [31:0]     rd_word;

  // Word index is AddrF[31:2]; upper bits never wrap, they only fail the range check.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_WORDS);
  endfunction

  // Build-time program image: word i holds "addi x1, x0, 5+i".
  function automatic logic [31:0] rom_word(input logic [IdxW-1:0] idx);
    return 32'h00500093 + (32'(idx) << 20);
  endfunction

  // With zero wait states the fetch is served from AddrF on the handshake edge;
  // otherwise it comes from the address captured at the handshake.
  assign fetch_addr  = (state_q == StWait) ? addr_q : AddrF;
  assign fetch_idx   = fetch_addr[IdxW+1:2];
  assign fetch_fault = addr_fault(fetch_addr);
  assign hs          = ReqF && ReadyF;
  assign enter_resp  = ((state_q == StWait) && (cnt_q == 3'd0) && !Flush) || (NoWait && hs);

`ifdef IMEM_WRITE_EN
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        wr_ok;

  assign wr_ok = WrEn && (WrAddr[1:0] == 2'b00) && ({2'b00, WrAddr[31:2]} < DEPTH_WORDS);

  // Program-load write; reset blocks the write but never clears the contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[WrAddr[IdxW+1:2]] <= WrData;
    end
  end

  // Read-before-write: a write on the RESP entry edge is not seen by this fetch.
  assign rd_word = mem_q[fetch_idx];
`else
  logic unused_wr;

  assign rd_word   = rom_word(fetch_idx);
  assign unused_wr = ^{WrEn, WrAddr, WrData};
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; Flush overrides everything except reset.
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            state_d = NoWait ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            state_d = StResp;
          end
        end
        StResp: begin
          if (RspAck) begin
            if (hs) begin
              state_d = NoWait ? StResp : StWait;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: acceptance is combinational so back-to-back fetches need no bubble.
  always_comb begin
    ReadyF   = 1'b0;
    RspValid = 1'b0;
    unique case (state_q)
      StIdle:  ReadyF = !Flush;
      StWait:  ReadyF = 1'b0;
      StResp: begin
        ReadyF   = RspAck && !Flush;
        RspValid = 1'b1;
      end
      default: ReadyF = 1'b0;
    endcase
  end

  // Wait-state counter and request address capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 3'd0;
      addr_q <= 32'h0;
    end else if (hs) begin
      cnt_q  <= CntLoad;
      addr_q <= AddrF;
    end else if ((state_q == StWait) && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // Response registers load only on RESP entry, so they hold until acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q  <= 32'h0;
      rsp_addr_q  <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_data_q  <= fetch_fault ? FAULT_INSTR : rd_word;
      rsp_addr_q  <= fetch_addr;
      rsp_fault_q <= fetch_fault;
    end
  end

  assign RspData  = rsp_data_q;
  assign RspAddr  = rsp_addr_q;
  assign RspFault = rsp_fault_q;

endmodule
